// File: rtl/w_input_conditioner_pkg.sv
// Shared definitions for the W input conditioner and the downstream detector stages.
//   deb_state_e          : debounce FSM encoding (ST_STABLE = 0, ST_CHECK = 1)
//   DEF_SYNC_STAGES      : default metastability chain depth
//   DEF_DEBOUNCE_CYCLES  : default number of agreeing samples needed to accept a new level
package w_input_conditioner_pkg;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_CHECK  = 1'b1
   } deb_state_e;

   localparam int unsigned DEF_SYNC_STAGES     = 2;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/w_sync_chain.sv
// Metastability synchroniser: a SYNC_STAGES-deep flop chain with asynchronous reset to 0.
// Ports:
//   clk    in  sampling clock
//   reset  in  asynchronous, active-high reset
//   i_d    in  asynchronous input
//   o_q    out synchronised output (last stage of the chain)
module w_sync_chain #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_chain;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/w_input_conditioner.sv
// Conditions the raw asynchronous W line for the Mealy sequence detector: synchronises it,
// debounces it and drives registered complementary W / _W that change only on clk rising edges.
// Optional build macro: W_EDGE_EN adds registered one-cycle w_rise / w_fall pulses.
// Ports:
//   clk       in  single clock
//   reset     in  asynchronous, active-high reset
//   w_raw     in  raw asynchronous input
//   W         out conditioned level
//   _W        out complement of W, from the same register
//   w_stable  out 1 when no level change is pending
//   w_rise    out (W_EDGE_EN) pulse on the edge W goes 0->1
//   w_fall    out (W_EDGE_EN) pulse on the edge W goes 1->0
module w_input_conditioner
   import w_input_conditioner_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic w_raw,
   output logic W,
   output logic _W,
   output logic w_stable
`ifdef W_EDGE_EN
   ,
   output logic w_rise,
   output logic w_fall
`endif
);

   localparam logic [CNT_W:0] LP_CNT_TGT = (CNT_W + 1)'(DEBOUNCE_CYCLES);

   logic           w_sync;
   deb_state_e     r_state, w_state_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d;
   logic [CNT_W:0] w_cnt_inc;
   logic           r_w, w_w_d;

   w_sync_chain #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (w_raw),
      .o_q   (w_sync)
   );

   // One bit wider than the counter so the terminal compare cannot wrap.
   assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_w_d     = r_w;
      case (r_state)
         ST_STABLE: begin
            if (w_sync != r_w) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  w_w_d = ~r_w;
               end else begin
                  w_cnt_d   = CNT_W'(1);
                  w_state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            if (w_sync == r_w) begin
               // Bounce back to the current level: abandon the pending change.
               w_cnt_d   = '0;
               w_state_d = ST_STABLE;
            end else if (w_cnt_inc == LP_CNT_TGT) begin
               w_w_d     = ~r_w;
               w_cnt_d   = '0;
               w_state_d = ST_STABLE;
            end else begin
               w_cnt_d = w_cnt_inc[CNT_W-1:0];
            end
         end
         default: begin
            w_cnt_d   = '0;
            w_state_d = ST_STABLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_STABLE;
         r_cnt   <= '0;
         r_w     <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_w     <= w_w_d;
      end
   end

   assign W        = r_w;
   assign _W       = ~r_w;
   assign w_stable = (r_state == ST_STABLE);

`ifdef W_EDGE_EN
   logic r_rise, r_fall;

   // Registered from the next-state of W so the pulse lands on the same edge W toggles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_w_d & ~r_w;
         r_fall <= ~w_w_d & r_w;
      end
   end

   assign w_rise = r_rise;
   assign w_fall = r_fall;
`endif

endmodule

// File: tb/tb_w_input_conditioner.sv
module tb_w_input_conditioner;
   import w_input_conditioner_pkg::*;

   localparam int unsigned SYNC = 2;
   localparam int unsigned DEB  = 4;

   logic clk = 1'b0;
   logic reset;
   logic w_raw;
   logic dut_w, dut_nw, dut_stable;
`ifdef W_EDGE_EN
   logic dut_rise, dut_fall;
`endif

   always #5 clk = ~clk;

   w_input_conditioner #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .w_raw    (w_raw),
      .W        (dut_w),
      ._W       (dut_nw),
      .w_stable (dut_stable)
`ifdef W_EDGE_EN
      ,
      .w_rise   (dut_rise),
      .w_fall   (dut_fall)
`endif
   );

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: W flips once DEB consecutive synchronised samples disagree with it;
   // the synchroniser is just a delay line of SYNC raw samples.
   logic q[$];
   logic m_w, m_stable, m_rise, m_fall;
   int   m_run;

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < SYNC; i++) q.push_back(1'b0);
      m_w = 1'b0; m_run = 0; m_stable = 1'b1; m_rise = 1'b0; m_fall = 1'b0;
   endtask

   task automatic model_edge(input logic raw);
      logic s;
      s = q[0];
      void'(q.pop_front());
      q.push_back(raw);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_w) begin
         m_run++;
         if (m_run == DEB) begin
            m_w    = ~m_w;
            m_run  = 0;
            m_rise = m_w;
            m_fall = ~m_w;
         end
      end else begin
         m_run = 0;
      end
      m_stable = (m_run == 0);
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".W"}, dut_w, m_w);
      chk({tag, "._W"}, dut_nw, ~m_w);
      chk({tag, ".w_stable"}, dut_stable, m_stable);
`ifdef W_EDGE_EN
      chk({tag, ".w_rise"}, dut_rise, m_rise);
      chk({tag, ".w_fall"}, dut_fall, m_fall);
      chk({tag, ".rise_and_fall"}, dut_rise & dut_fall, 1'b0);
`endif
   endtask

   // One clock edge, model update, then sample outputs 1 ns after the edge.
   task automatic step(input string tag);
      @(posedge clk);
      if (reset) model_reset();
      else model_edge(w_raw);
      #1;
      check_all(tag);
   endtask

   // Assert reset away from an edge and check it acts immediately.
   task automatic async_reset(input string tag);
      reset = 1'b1;
      #1;
      model_reset();
      check_all(tag);
   endtask

   typedef struct {
      logic raw;
      logic w;
      logic stable;
   } vec_t;

   vec_t tbl[22];

   initial begin
      // 0->1 held: w_stable drops at edge 3, W rises at edge 6.
      tbl[0]  = '{1'b1, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 1'b1};
      // 1->0 held: mirror image.
      tbl[7]  = '{1'b0, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 1'b1};
      // Three-sample pulse: never reaches W, w_stable recovers.
      tbl[14] = '{1'b1, 1'b0, 1'b1};
      tbl[15] = '{1'b1, 1'b0, 1'b1};
      tbl[16] = '{1'b1, 1'b0, 1'b0};
      tbl[17] = '{1'b0, 1'b0, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 1'b0};
      tbl[19] = '{1'b0, 1'b0, 1'b1};
      tbl[20] = '{1'b0, 1'b0, 1'b1};
      tbl[21] = '{1'b0, 1'b0, 1'b1};

      w_raw = 1'b0;
      reset = 1'b0;
      #2;
      async_reset("init");
      step("init_hold");
      #2 reset = 1'b0;
      step("idle");
      step("idle");

      for (int i = 0; i < 22; i++) begin
         w_raw = tbl[i].raw;
         step($sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.W", i), dut_w, tbl[i].w);
         chk($sformatf("tbl%0d.stable", i), dut_stable, tbl[i].stable);
      end

      // Reset with w_raw high: immediate clear, W rises at edge 6 after release.
      w_raw = 1'b1;
      #2;
      async_reset("rst_raw1");
      chk("rst_raw1.W", dut_w, 1'b0);
      chk("rst_raw1.stable", dut_stable, 1'b1);
      step("rst_raw1_hold");
      step("rst_raw1_hold");
      chk("rst_hold.W", dut_w, 1'b0);
      reset = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         step("post_rst");
         chk($sformatf("post_rst_e%0d.W", e), dut_w, (e == 6) ? 1'b1 : 1'b0);
      end

      // Return to W = 0, then bounce 1,0,1,0 before holding 1.
      w_raw = 1'b0;
      for (int e = 0; e < 8; e++) step("settle0");
      chk("settle0.W", dut_w, 1'b0);
      for (int b = 0; b < 4; b++) begin
         w_raw = (b % 2 == 0) ? 1'b1 : 1'b0;
         step("bounce");
         chk("bounce.W", dut_w, 1'b0);
      end
      w_raw = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step("bounce_hold");
         chk($sformatf("bounce_hold_e%0d.W", e), dut_w, (e == 6) ? 1'b1 : 1'b0);
      end

      // Reset mid-CHECK aborts the pending rise.
      w_raw = 1'b0;
      for (int e = 0; e < 8; e++) step("settle1");
      w_raw = 1'b1;
      for (int e = 0; e < 4; e++) step("pre_abort");
      chk("pre_abort.stable", dut_stable, 1'b0);
      async_reset("abort");
      chk("abort.W", dut_w, 1'b0);
      chk("abort.stable", dut_stable, 1'b1);
      w_raw = 1'b0;
      step("abort_hold");
      reset = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         step("after_abort");
         chk($sformatf("after_abort_e%0d.W", e), dut_w, 1'b0);
      end

      // Random run lengths with occasional asynchronous resets.
      for (int n = 0; n < 150; n++) begin
         int len;
         w_raw = 1'($urandom_range(0, 1));
         len   = $urandom_range(1, 7);
         for (int j = 0; j < len; j++) step("rand");
         if ($urandom_range(0, 29) == 0) begin
            #2;
            async_reset("rand_rst");
            step("rand_rst_hold");
            reset = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
